// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial pattern detector with mask and match counter
//
// Purpose:
//   Watches a qualified serial bit stream and pulses `out` for one cycle each
//   time the last PAT_W consumed bits equal the programmed pattern (bits whose
//   mask is 0 are ignored). Counts matches in a saturating counter with a
//   sticky saturation flag.
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous active-high reset
//   in_valid     in   1      `in` is consumed only on edges where this is 1
//   in           in   1      serial data bit
//   overlap      in   1      1: history kept after a match, 0: history flushed
//   cfg_we       in   1      load cfg_pattern/cfg_mask, flush history
//   cfg_pattern  in   PAT_W  pattern; bit 0 is compared with the newest bit
//   cfg_mask     in   PAT_W  1 = compare this bit, 0 = don't care
//   cnt_clr      in   1      synchronous clear of match_count and cnt_sat
//   out          out  1      registered one-cycle match pulse
//   match_count  out  CNT_W  saturating match counter
//   cnt_sat      out  1      sticky: counter has reached all ones

module seq_detector_param #(
    parameter int              PAT_W   = 6,
    parameter logic [PAT_W-1:0] DEF_PAT = 6'b110011,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    // Fill counter must be able to hold the value PAT_W itself.
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  r_pattern;
    logic [PAT_W-1:0]  r_mask;
    logic              r_out;
    logic [CNT_W-1:0]  r_count;
    logic              r_sat;

    logic              w_consume;
    logic [PAT_W-1:0]  w_nh;
    logic [FILL_W-1:0] w_fill_next;
    logic              w_cmp_ok;
    logic              w_match;
    logic              w_cnt_max;
    logic [CNT_W-1:0]  w_cnt_next;

    // A configuration write takes priority and swallows any bit on that edge.
    assign w_consume   = in_valid && !cfg_we;
    assign w_nh        = {r_hist[PAT_W-2:0], in};
    assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : (r_fill + 1'b1);
    assign w_cmp_ok    = (((w_nh ^ r_pattern) & r_mask) == '0);

    // Warm-up gate: the fill count, not the history contents, decides whether
    // enough real bits are present, so reset zeros can never complete a match.
    assign w_match     = w_consume && (w_fill_next == FILL_FULL) && w_cmp_ok;

    assign w_cnt_max   = &r_count;
    assign w_cnt_next  = r_count + 1'b1;

    // History, fill and configuration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= DEF_PAT;
            r_mask    <= '1;
        end else if (cfg_we) begin
            r_pattern <= cfg_pattern;
            r_mask    <= cfg_mask;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (in_valid) begin
            if (w_match && !overlap) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_nh;
                r_fill <= w_fill_next;
            end
        end
    end

    // Match pulse: w_match is already 0 on idle and config edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_match;
        end
    end

    // Saturating counter; clear beats a coincident match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (cnt_clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_match && !w_cnt_max) begin
            r_count <= w_cnt_next;
            if (&w_cnt_next) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign out         = r_out;
    assign match_count = r_count;
    assign cnt_sat     = r_sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param

module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       r_valid;
    logic       r_in;
    logic       r_overlap;
    logic       r_cfg_we;
    logic [5:0] r_cfg_pat;
    logic [5:0] r_cfg_mask;
    logic       r_clr;

    logic       out_a;
    logic [7:0] cnt_a;
    logic       sat_a;
    logic       out_b;
    logic [1:0] cnt_b;
    logic       sat_b;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(6), .DEF_PAT(6'b110011), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(r_valid), .in(r_in), .overlap(r_overlap),
        .cfg_we(r_cfg_we), .cfg_pattern(r_cfg_pat), .cfg_mask(r_cfg_mask), .cnt_clr(r_clr),
        .out(out_a), .match_count(cnt_a), .cnt_sat(sat_a)
    );

    seq_detector_param #(.PAT_W(6), .DEF_PAT(6'b110011), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(r_valid), .in(r_in), .overlap(r_overlap),
        .cfg_we(r_cfg_we), .cfg_pattern(r_cfg_pat), .cfg_mask(r_cfg_mask), .cnt_clr(r_clr),
        .out(out_b), .match_count(cnt_b), .cnt_sat(sat_b)
    );

    typedef struct {
        logic       o;
        logic [7:0] c8;
        logic       s8;
        logic [1:0] c2;
        logic       s2;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [5:0] m_hist;
    int         m_fill;
    logic [5:0] m_pat;
    logic [5:0] m_mask;
    int         m_c8;
    logic       m_s8;
    int         m_c2;
    logic       m_s2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = '0;
        m_fill = 0;
        m_pat  = 6'b110011;
        m_mask = 6'b111111;
        m_c8   = 0;
        m_s8   = 1'b0;
        m_c2   = 0;
        m_s2   = 1'b0;
    endtask

    // Drive one edge from the negedge, predict, check just after the posedge.
    task automatic step(input logic v, input logic b, input logic we,
                        input logic [5:0] pat, input logic [5:0] msk, input logic clr);
        exp_t       e;
        exp_t       g;
        logic [5:0] nh;
        int         nf;
        bit         mt;
        int         bit_i;
        r_valid    = v;
        r_in       = b;
        r_cfg_we   = we;
        r_cfg_pat  = pat;
        r_cfg_mask = msk;
        r_clr      = clr;
        mt = 1'b0;
        if (we) begin
            m_pat  = pat;
            m_mask = msk;
            m_hist = '0;
            m_fill = 0;
        end else if (v) begin
            nh = {m_hist[4:0], b};
            nf = (m_fill + 1 > 6) ? 6 : m_fill + 1;
            mt = 1'b1;
            for (int i = 0; i < 6; i++) begin
                bit_i = i;
                if (m_mask[bit_i] && (nh[bit_i] != m_pat[bit_i])) mt = 1'b0;
            end
            if (nf != 6) mt = 1'b0;
            if (mt && !r_overlap) begin
                m_hist = '0;
                m_fill = 0;
            end else begin
                m_hist = nh;
                m_fill = nf;
            end
        end
        if (clr) begin
            m_c8 = 0; m_s8 = 1'b0; m_c2 = 0; m_s2 = 1'b0;
        end else if (mt) begin
            if (m_c8 < 255) m_c8++;
            if (m_c8 == 255) m_s8 = 1'b1;
            if (m_c2 < 3) m_c2++;
            if (m_c2 == 3) m_s2 = 1'b1;
        end
        e.o  = mt;
        e.c8 = 8'(m_c8);
        e.s8 = m_s8;
        e.c2 = 2'(m_c2);
        e.s2 = m_s2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("out",     32'(out_a), 32'(g.o));
        chk("out_b",   32'(out_b), 32'(g.o));
        chk("count",   32'(cnt_a), 32'(g.c8));
        chk("sat",     32'(sat_a), 32'(g.s8));
        chk("count_b", 32'(cnt_b), 32'(g.c2));
        chk("sat_b",   32'(sat_b), 32'(g.s2));
        @(negedge clk);
        r_valid  = 1'b0;
        r_cfg_we = 1'b0;
        r_clr    = 1'b0;
    endtask

    task automatic bitv(input logic b);
        step(1'b1, b, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bitv(s[i] == "1");
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    // A bit is offered alongside the write so that its discard is exercised.
    task automatic cfg(input logic [5:0] pat, input logic [5:0] msk);
        step(1'b1, 1'b1, 1'b1, pat, msk, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out",   32'(out_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_sat",   32'(sat_a), 32'd0);
        chk("rst_cnt_b", 32'(cnt_b), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        r_valid    = 1'b0;
        r_in       = 1'b0;
        r_overlap  = 1'b1;
        r_cfg_we   = 1'b0;
        r_cfg_pat  = '0;
        r_cfg_mask = '0;
        r_clr      = 1'b0;
        model_reset();
        @(negedge clk);
        chk("init_out",   32'(out_a), 32'd0);
        chk("init_count", 32'(cnt_a), 32'd0);
        chk("init_sat",   32'(sat_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Default pattern, overlapping: two matches 4 edges apart
        r_overlap = 1'b1;
        feed("110011");
        chk("tp1_count", 32'(cnt_a), 32'd1);
        feed("0011");
        chk("tp2_count", 32'(cnt_a), 32'd2);

        // Same stream without overlap: one match only
        do_reset();
        r_overlap = 1'b0;
        feed("1100110011");
        chk("tp2b_count", 32'(cnt_a), 32'd1);

        // All-zero pattern: warm-up, then a pulse on every edge
        r_overlap = 1'b1;
        cfg(6'b000000, 6'b111111);
        feed("00000");
        chk("warm_count", 32'(cnt_a), 32'd1);
        feed("000000");
        chk("zeros_count", 32'(cnt_a), 32'd7);
        chk("sat2_count",  32'(cnt_b), 32'd3);
        chk("sat2_flag",   32'(sat_b), 32'd1);

        // Clear coinciding with a match: pulse still, count cleared
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        chk("clr_count", 32'(cnt_a), 32'd0);
        chk("clr_sat_b", 32'(sat_b), 32'd0);
        feed("00");

        // Masked compare (bit 3 don't care)
        r_overlap = 1'b0;
        cfg(6'b110011, 6'b110111);
        feed("110011");
        feed("111011");
        feed("100011");
        chk("mask_count", 32'(cnt_a), 32'd4);

        // All don't care: every consumed bit after warm-up matches
        r_overlap = 1'b1;
        cfg(6'b101010, 6'b000000);
        feed("0110101");

        // in_valid gaps
        cfg(6'b110011, 6'b111111);
        feed("110");
        idle(); idle(); idle();
        feed("011");
        idle();

        // Reset mid-stream loses the partial match
        feed("1100");
        do_reset();
        feed("11");
        chk("rst_mid_count", 32'(cnt_a), 32'd0);

        // Random traffic against the model
        r_overlap = 1'b1;
        cfg(6'b101101, 6'b111011);
        for (int k = 0; k < 200; k++) begin
            r_overlap = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0), 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 63)), 1'($urandom_range(0, 30) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
